// File: rtl/pll_ctl_pkg.sv
// Shared types for the PLL reconfiguration sequencer.
// States, result codes and the PLL_INTERFACE data packing.
package pll_ctl_pkg;

    typedef logic [7:0] factor_t;

    typedef enum logic [3:0] {
        INIT,
        IDLE,
        CHECK,
        WAIT_IDLE,
        TRIGGER,
        WAIT_BUSY,
        WAIT_DONE,
        WAIT_LOCK,
        FINISH
    } state_t;

    typedef enum logic [2:0] {
        ST_OK             = 3'd0,
        ST_BAD_FACTOR     = 3'd1,
        ST_BUSY_TIMEOUT   = 3'd2,
        ST_RECONF_TIMEOUT = 3'd3,
        ST_LOCK_TIMEOUT   = 3'd4,
        ST_LOCK_LOST      = 3'd5,
        ST_SKIPPED        = 3'd6
    } status_t;

    function automatic logic [15:0] pack_pll_data(
        input factor_t mult,
        input factor_t div
    );
        return {mult, div};
    endfunction

endpackage

// File: rtl/pll_lock_monitor.sv
// Synchronizes the asynchronous PLL lock and counts consecutive
// locked cycles; settled holds once the count reaches SETTLE_CYCLES.
module pll_lock_monitor #(
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic lock_async_i,
    input  logic clear_i,
    output logic lock_s_o,
    output logic settled_o
);

    localparam logic [15:0] SettleMax = 16'(SETTLE_CYCLES);

    logic        sync1_q;
    logic        sync2_q;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !sync2_q) begin
            cnt_d = '0;
        end else if (cnt_q != SettleMax) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= lock_async_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
        end
    end

    assign lock_s_o  = sync2_q;
    assign settled_o = (cnt_q == SettleMax);

endmodule

// File: rtl/pll_reconfig_sequencer.sv
// Run-time PLL reconfiguration sequencer: validates a mult/div request,
// drives the trigger/busy handshake and holds c0 consumers until relock.
module pll_reconfig_sequencer
    import pll_ctl_pkg::*;
#(
    parameter int unsigned TRIGGER_CYCLES = 5,
    parameter int unsigned BUSY_TIMEOUT   = 1024,
    parameter int unsigned RECONF_TIMEOUT = 65535,
    parameter int unsigned LOCK_TIMEOUT   = 4096,
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter factor_t     INIT_MULT      = 8'd1,
    parameter factor_t     INIT_DIV       = 8'd1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_mult,
    input  logic [7:0]  req_div,
    output logic [15:0] pll_data,
    output logic        pll_trigger,
    input  logic        pll_busy,
    input  logic        pll_locked,
    output logic        clk_hold,
    output logic        done,
    output logic        error,
    output logic [2:0]  status,
    output logic [7:0]  cur_mult,
    output logic [7:0]  cur_div
);

    localparam logic [15:0] TrigLast   = 16'(TRIGGER_CYCLES - 1);
    localparam logic [15:0] BusyLast   = 16'(BUSY_TIMEOUT - 1);
    localparam logic [15:0] ReconfLast = 16'(RECONF_TIMEOUT - 1);
    localparam logic [15:0] LockLast   = 16'(LOCK_TIMEOUT - 1);

    state_t      state_q, state_d;
    status_t     status_q, status_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] data_q, data_d;
    factor_t     cur_mult_q, cur_mult_d;
    factor_t     cur_div_q, cur_div_d;
    logic        seen_busy_q, seen_busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        trig_q, trig_d;
    logic        hold_q, hold_d;

    logic        lock_s;
    logic        settled;
    logic        state_change;
    logic [15:0] cur_data;

    assign state_change = (state_d != state_q);
    assign cur_data     = pack_pll_data(cur_mult_q, cur_div_q);

    pll_lock_monitor #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_lock_mon (
        .clock       (clock),
        .reset       (reset),
        .lock_async_i(pll_locked),
        .clear_i     (state_change),
        .lock_s_o    (lock_s),
        .settled_o   (settled)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= INIT;
            status_q    <= ST_OK;
            timer_q     <= '0;
            data_q      <= pack_pll_data(INIT_MULT, INIT_DIV);
            cur_mult_q  <= INIT_MULT;
            cur_div_q   <= INIT_DIV;
            seen_busy_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            trig_q      <= 1'b0;
            hold_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            status_q    <= status_d;
            timer_q     <= timer_d;
            data_q      <= data_d;
            cur_mult_q  <= cur_mult_d;
            cur_div_q   <= cur_div_d;
            seen_busy_q <= seen_busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            trig_q      <= trig_d;
            hold_q      <= hold_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        status_d   = status_q;
        data_d     = data_q;
        cur_mult_d = cur_mult_q;
        cur_div_d  = cur_div_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        unique case (state_q)
            INIT: begin
                if (settled) state_d = IDLE;
            end
            IDLE: begin
                if (!lock_s) begin
                    state_d  = INIT;
                    error_d  = 1'b1;
                    status_d = ST_LOCK_LOST;
                end else if (req_valid) begin
                    data_d  = pack_pll_data(req_mult, req_div);
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (data_q[15:8] == 8'd0 || data_q[7:0] == 8'd0) begin
                    data_d   = cur_data;
                    done_d   = 1'b1;
                    error_d  = 1'b1;
                    status_d = ST_BAD_FACTOR;
                    state_d  = IDLE;
                end else if (data_q == cur_data) begin
                    done_d   = 1'b1;
                    status_d = ST_SKIPPED;
                    state_d  = IDLE;
                end else begin
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (!pll_busy) begin
                    state_d = TRIGGER;
                end else if (timer_q >= BusyLast) begin
                    done_d   = 1'b1;
                    error_d  = 1'b1;
                    status_d = ST_BUSY_TIMEOUT;
                    state_d  = INIT;
                end
            end
            TRIGGER: begin
                if (timer_q == TrigLast) state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (pll_busy || seen_busy_q) begin
                    state_d = WAIT_DONE;
                end else if (timer_q >= BusyLast) begin
                    done_d   = 1'b1;
                    error_d  = 1'b1;
                    status_d = ST_BUSY_TIMEOUT;
                    state_d  = INIT;
                end
            end
            WAIT_DONE: begin
                if (!pll_busy) begin
                    state_d = WAIT_LOCK;
                end else if (timer_q >= ReconfLast) begin
                    done_d   = 1'b1;
                    error_d  = 1'b1;
                    status_d = ST_RECONF_TIMEOUT;
                    state_d  = INIT;
                end
            end
            WAIT_LOCK: begin
                if (settled) begin
                    state_d = FINISH;
                end else if (timer_q >= LockLast) begin
                    done_d   = 1'b1;
                    error_d  = 1'b1;
                    status_d = ST_LOCK_TIMEOUT;
                    state_d  = INIT;
                end
            end
            FINISH: begin
                cur_mult_d = data_q[15:8];
                cur_div_d  = data_q[7:0];
                done_d     = 1'b1;
                status_d   = ST_OK;
                state_d    = IDLE;
            end
            default: state_d = INIT;
        endcase
    end

    // The busy timer runs from trigger rise, so it survives TRIGGER -> WAIT_BUSY.
    always_comb begin
        timer_d = timer_q;
        if (state_change && state_d != WAIT_BUSY) begin
            timer_d = '0;
        end else if (timer_q != 16'hFFFF) begin
            timer_d = timer_q + 16'd1;
        end
        seen_busy_d = (state_q == TRIGGER) && (seen_busy_q || pll_busy);
        trig_d      = (state_d == TRIGGER);
        hold_d      = !(state_d == IDLE || state_d == CHECK);
    end

    assign req_ready   = (state_q == IDLE) && lock_s;
    assign pll_data    = data_q;
    assign pll_trigger = trig_q;
    assign clk_hold    = hold_q;
    assign done        = done_q;
    assign error       = error_q;
    assign status      = status_q;
    assign cur_mult    = cur_mult_q;
    assign cur_div     = cur_div_q;

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// Directed bench for pll_reconfig_sequencer with a small PLL_INTERFACE
// model; request table plus hand sequences for timeouts and reset.
module tb_pll_reconfig_sequencer;

    localparam int TRIG   = 5;
    localparam int BUSYTO = 1024;
    localparam int LOCKTO = 4096;
    localparam int SETTLE = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_mult = 8'd0;
    logic [7:0]  req_div = 8'd0;
    logic [15:0] pll_data;
    logic        pll_trigger;
    logic        pll_busy = 1'b0;
    logic        pll_locked = 1'b0;
    logic        clk_hold;
    logic        done;
    logic        error;
    logic [2:0]  status;
    logic [7:0]  cur_mult;
    logic [7:0]  cur_div;

    always #5 clock = ~clock;

    pll_reconfig_sequencer #(
        .TRIGGER_CYCLES(TRIG),
        .BUSY_TIMEOUT  (BUSYTO),
        .RECONF_TIMEOUT(65535),
        .LOCK_TIMEOUT  (LOCKTO),
        .SETTLE_CYCLES (SETTLE),
        .INIT_MULT     (8'd1),
        .INIT_DIV      (8'd1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_mult   (req_mult),
        .req_div    (req_div),
        .pll_data   (pll_data),
        .pll_trigger(pll_trigger),
        .pll_busy   (pll_busy),
        .pll_locked (pll_locked),
        .clk_hold   (clk_hold),
        .done       (done),
        .error      (error),
        .status     (status),
        .cur_mult   (cur_mult),
        .cur_div    (cur_div)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    // PLL model: busy 3 cycles after trigger rise for 200 cycles,
    // lock drops with busy and returns 100 cycles after busy falls.
    logic lock_ok = 1'b0;
    logic never_busy = 1'b0;
    logic never_lock = 1'b0;
    logic m_trig_prev = 1'b0;
    int   m_phase = 0;
    int   m_cnt = 0;

    always @(negedge clock) begin
        #1;
        if (pll_trigger && !m_trig_prev && m_phase == 0) begin
            m_phase = 1;
            m_cnt = 0;
        end
        m_trig_prev = pll_trigger;
        case (m_phase)
            0: pll_locked = lock_ok;
            1: begin
                if (never_busy) begin
                    m_phase = 0;
                end else begin
                    m_cnt++;
                    if (m_cnt == 3) begin
                        pll_busy = 1'b1;
                        pll_locked = 1'b0;
                        m_phase = 2;
                        m_cnt = 0;
                    end
                end
            end
            2: begin
                m_cnt++;
                if (m_cnt == 200) begin
                    pll_busy = 1'b0;
                    m_phase = 3;
                    m_cnt = 0;
                end
            end
            3: begin
                if (!never_lock) begin
                    m_cnt++;
                    if (m_cnt == 100) begin
                        pll_locked = lock_ok;
                        m_phase = 0;
                    end
                end
            end
            default: m_phase = 0;
        endcase
    end

    // Results of the last request
    logic        r_ready, r_done, r_err, r_hold, r_after;
    logic [2:0]  r_status;
    logic [15:0] r_data;
    int          r_trig, r_rise, r_done_idx, r_fall, r_hold_low;

    task automatic wait_ready(input string name, input int bound);
        int cyc;
        cyc = -1;
        for (int i = 0; i < bound; i++) begin
            if (req_ready) begin
                cyc = i;
                break;
            end
            @(negedge clock);
        end
        chk(name, int'(cyc >= 0), 1);
    endtask

    task automatic do_req(input logic [7:0] m, input logic [7:0] d,
                          input int bound);
        logic prev_busy;
        r_done = 1'b0; r_err = 1'b0; r_hold = 1'b0; r_after = 1'b0;
        r_status = 3'd7; r_data = 16'hxxxx;
        r_trig = 0; r_rise = -1; r_done_idx = -1; r_fall = -1;
        r_hold_low = 0;
        r_ready = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            if (req_ready) begin
                r_ready = 1'b1;
                break;
            end
            @(negedge clock);
        end
        req_valid = 1'b1;
        req_mult = m;
        req_div = d;
        @(negedge clock);
        req_valid = 1'b0;
        req_mult = 8'hAA;
        req_div = 8'h55;
        prev_busy = pll_busy;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clock);
            if (pll_trigger) begin
                r_trig++;
                if (r_rise < 0) r_rise = i;
            end
            if (!pll_busy && prev_busy && r_fall < 0) r_fall = i;
            prev_busy = pll_busy;
            if (done) begin
                r_done = 1'b1;
                r_done_idx = i;
                r_err = error;
                r_status = status;
                r_data = pll_data;
                r_hold = clk_hold;
                break;
            end
            if (!clk_hold) r_hold_low++;
        end
        if (r_done) begin
            @(negedge clock);
            r_after = done | error;
        end
    endtask

    typedef struct {
        logic [7:0]  m;
        logic [7:0]  d;
        logic [2:0]  st;
        logic        err;
        int          trig;
        logic [7:0]  cm;
        logic [7:0]  cd;
        logic [15:0] data;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int e_idx;
        logic e_done;
        logic e_hold;
        logic [2:0] e_st;
        int fall;

        tbl[0] = '{8'd6,   8'd3,   3'd0, 1'b0, TRIG, 8'd6,   8'd3,   16'h0603};
        tbl[1] = '{8'd0,   8'd8,   3'd1, 1'b1, 0,    8'd6,   8'd3,   16'h0603};
        tbl[2] = '{8'd6,   8'd3,   3'd6, 1'b0, 0,    8'd6,   8'd3,   16'h0603};
        tbl[3] = '{8'd9,   8'd0,   3'd1, 1'b1, 0,    8'd6,   8'd3,   16'h0603};
        tbl[4] = '{8'd255, 8'd255, 3'd0, 1'b0, TRIG, 8'd255, 8'd255, 16'hFFFF};
        tbl[5] = '{8'd255, 8'd255, 3'd6, 1'b0, 0,    8'd255, 8'd255, 16'hFFFF};
        tbl[6] = '{8'd1,   8'd1,   3'd0, 1'b0, TRIG, 8'd1,   8'd1,   16'h0101};
        tbl[7] = '{8'd6,   8'd3,   3'd0, 1'b0, TRIG, 8'd6,   8'd3,   16'h0603};

        // Reset state
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst_hold", int'(clk_hold), 1);
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_trig", int'(pll_trigger), 0);
        chk("rst_done", int'(done | error), 0);
        chk("rst_status", int'(status), 0);
        chk("rst_data", int'(pll_data), 16'h0101);
        chk("rst_cur", int'({cur_mult, cur_div}), 16'h0101);
        reset = 1'b0;

        // Power-up: 1 sample edge + 2 sync flops + SETTLE counted cycles
        repeat (50) @(negedge clock);
        lock_ok = 1'b1;
        fall = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clock);
            if (!clk_hold) begin
                fall = i;
                break;
            end
        end
        chk("pwr_hold_fall", fall, 3 + SETTLE);
        chk("pwr_ready", int'(req_ready), 1);
        chk("pwr_status", int'(status), 0);
        chk("pwr_cur", int'({cur_mult, cur_div}), 16'h0101);

        foreach (tbl[k]) begin
            do_req(tbl[k].m, tbl[k].d, 1000);
            chk($sformatf("v%0d_ready", k), int'(r_ready), 1);
            chk($sformatf("v%0d_done", k), int'(r_done), 1);
            chk($sformatf("v%0d_status", k), int'(r_status), int'(tbl[k].st));
            chk($sformatf("v%0d_error", k), int'(r_err), int'(tbl[k].err));
            chk($sformatf("v%0d_trig", k), r_trig, tbl[k].trig);
            chk($sformatf("v%0d_data", k), int'(r_data), int'(tbl[k].data));
            chk($sformatf("v%0d_cur", k), int'({cur_mult, cur_div}),
                int'({tbl[k].cm, tbl[k].cd}));
            chk($sformatf("v%0d_hold_gap", k), r_hold_low, 0);
            chk($sformatf("v%0d_hold_rel", k), int'(r_hold), 0);
            chk($sformatf("v%0d_pulse", k), int'(r_after), 0);
        end

        // Busy never rises
        never_busy = 1'b1;
        do_req(8'd20, 8'd2, 2000);
        chk("bto_done", int'(r_done), 1);
        chk("bto_status", int'(r_status), 2);
        chk("bto_error", int'(r_err), 1);
        chk("bto_trig", r_trig, TRIG);
        chk("bto_latency", r_done_idx - r_rise, BUSYTO);
        chk("bto_hold", int'(r_hold), 1);
        chk("bto_cur", int'({cur_mult, cur_div}), 16'h0603);
        never_busy = 1'b0;
        wait_ready("bto_resettle", 200);
        chk("bto_cur2", int'({cur_mult, cur_div}), 16'h0603);

        // Busy completes but lock never returns
        never_lock = 1'b1;
        do_req(8'd9, 8'd9, 6000);
        chk("lto_done", int'(r_done), 1);
        chk("lto_status", int'(r_status), 4);
        chk("lto_error", int'(r_err), 1);
        chk("lto_latency", r_done_idx - r_fall, LOCKTO);
        chk("lto_hold", int'(r_hold), 1);
        chk("lto_cur", int'({cur_mult, cur_div}), 16'h0603);
        never_lock = 1'b0;
        wait_ready("lto_resettle", 600);

        // Lock lost while idle
        lock_ok = 1'b0;
        e_idx = -1; e_done = 1'b1; e_hold = 1'b0; e_st = 3'd0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (error) begin
                e_idx = i;
                e_done = done;
                e_hold = clk_hold;
                e_st = status;
                break;
            end
        end
        chk("lost_latency", e_idx, 3);
        chk("lost_done", int'(e_done), 0);
        chk("lost_hold", int'(e_hold), 1);
        chk("lost_status", int'(e_st), 5);
        lock_ok = 1'b1;
        wait_ready("lost_resettle", 100);

        // Reset during the second trigger cycle
        never_busy = 1'b1;
        wait_ready("rtr_ready", 50);
        req_valid = 1'b1;
        req_mult = 8'd7;
        req_div = 8'd7;
        @(negedge clock);
        req_valid = 1'b0;
        fall = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (pll_trigger) begin
                fall = i;
                break;
            end
        end
        chk("rtr_trig_seen", int'(fall >= 0), 1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("rtr_trig_drop", int'(pll_trigger), 0);
        chk("rtr_ready", int'(req_ready), 0);
        chk("rtr_hold", int'(clk_hold), 1);
        chk("rtr_cur", int'({cur_mult, cur_div}), 16'h0101);
        chk("rtr_data", int'(pll_data), 16'h0101);
        chk("rtr_status", int'(status), 0);
        reset = 1'b0;
        @(negedge clock);
        chk("rtr_ready_held", int'(req_ready), 0);
        wait_ready("rtr_resettle", 100);
        never_busy = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
